mult_wb_buffer: RTL and testbench
=================================

// Module: mult_wb_buffer
// PURPOSE
//  Receiving end of the 1-cycle multiplier result interface (valid/result/trans_id, no backpressure).
//  Buffers multiplier results in a small FIFO and presents them to the writeback port with valid/ready.
//  Issues credit to the issue stage so that no result is ever lost, because the multiplier cannot stall.
//  Sits between the multiplier output and the scoreboard writeback arbiter.
// PARAMETERS
//  DEPTH        4                        FIFO entries; power of two, >= 2
//  TRANS_ID_BITS ariane_pkg::TRANS_ID_BITS  scoreboard tag width (package constant, not overridden)
// PORTS
//  clk_i            in   1              clock
//  rst_ni           in   1              asynchronous reset, active-low
//  flush_i          in   1              pipeline flush: discard buffered and in-flight results
//  issue_valid_i    in   1              a multiply op is presented to the multiplier this cycle
//  issue_ready_o    out  1              credit available; the issue stage may launch a multiply
//  mult_valid_i     in   1              multiplier result valid (1 cycle after an accepted issue)
//  mult_result_i    in   64             multiplier result
//  mult_trans_id_i  in   TRANS_ID_BITS  tag of the result
//  wb_valid_o       out  1              FIFO head valid
//  wb_ready_i       in   1              writeback accepts the head
//  wb_result_o      out  64             head result
//  wb_trans_id_o    out  TRANS_ID_BITS  head tag
//  count_o          out  $clog2(DEPTH)+1  occupied entries (debug/perf)
// BEHAVIOUR
//  Reset (async, rst_ni=0)
//  - FIFO empty; pointers = 0; inflight_q = 0.
//  - wb_valid_o = 0; wb_result_o = 0; wb_trans_id_o = 0; count_o = 0.
//  - issue_ready_o = 1 once DEPTH >= 1 (combinational from the reset state).
//  Issue and credit
//  - issue = issue_valid_i & issue_ready_o & ~flush_i.
//  - inflight_q <= issue; the multiplier latency is exactly 1, so at most one op is in flight.
//  - issue_ready_o = ~flush_i & ((count + inflight_q - pop) < DEPTH), where pop = wb_valid_o & wb_ready_i.
//  - This is computed combinationally in the same cycle. A pop in the current cycle frees a slot
//    for the current issue.
//  Push
//  - push = mult_valid_i & inflight_q & ~flush_i.
//  - mult_valid_i with inflight_q = 0 is a stale result from a flushed op: silently dropped.
//  - The entry written is {mult_result_i, mult_trans_id_i} at the write pointer; wptr++.
//  Pop
//  - The head is driven from storage at the read pointer (no same-cycle bypass).
//  - Minimum latency mult_valid_i -> wb_valid_o is therefore 1 cycle.
//  - On pop, rptr++. Outputs hold stable while wb_valid_o & ~wb_ready_i.
//  Pointers and count
//  - Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
//  - Full  = MSBs differ and LSBs equal; empty = pointers equal.
//  - count_o = wptr - rptr.
//  Simultaneous events
//  - push & pop in the same cycle (including when full or empty): count unchanged, both performed.
//  - flush_i has priority over push, pop and issue.
//  - On flush: rptr = wptr = 0, inflight_q = 0, wb_valid_o = 0 next cycle.
//  - A pop handshake in the flush cycle is still observed by the consumer; the RTL ignores it.
//  - A result arriving the cycle after a flush is dropped via inflight_q = 0.
//  Error checks (assertions, simulation only)
//  - push while full.
//  - mult_valid_i = 0 while inflight_q = 1.
//  - wb_* outputs change while wb_valid_o & ~wb_ready_i.
//  Reset mid-operation
//  - All state returns to the reset values above.
//  - Results in flight are lost; the scoreboard is reset concurrently.
// STRUCTURE
//  - ariane_pkg: use the existing TRANS_ID_BITS.
//  - ariane_pkg: add typedef struct packed {logic [63:0] result; logic [TRANS_ID_BITS-1:0] trans_id;} mult_wb_t;
//  - Sub-module: fifo_v2-style generic sync FIFO (name: wb_fifo, params DEPTH, type dtype = mult_wb_t)
//    holding storage and pointers.
//  - The top level holds only the credit/in-flight logic and the flush/drop control.
// TESTING
//  1 Reset: hold rst_ni=0 for 3 cycles.
//    -> wb_valid_o=0, count_o=0, issue_ready_o=1; wb outputs are 0.
//  2 Single op: issue tag 5; next cycle result 0xDEAD_BEEF/tag 5.
//    -> wb_valid_o=1 the following cycle with that data; pop with wb_ready_i=1 -> count_o=0.
//  3 Fill/backpressure: DEPTH=4, wb_ready_i=0, issue every cycle.
//    -> exactly 4 issues accepted; issue_ready_o=0 from the 5th; count_o=4.
//    -> No assertion fires; all 4 tags are read out in order 0..3.
//  4 Full with concurrent pop: count=3, inflight_q=1, wb_ready_i=1, issue_valid_i=1.
//    -> issue accepted (pop frees a slot); count_o stays 4 max; no overflow.
//  5 Flush: 2 entries buffered, 1 in flight, assert flush_i for 1 cycle.
//    -> next cycle count_o=0, wb_valid_o=0; the arriving in-flight result (tag 7) is dropped.
//    -> issue_ready_o=0 during flush, 1 after.
//  6 Reset mid-operation: 3 entries plus 1 in flight, pull rst_ni low asynchronously (off clock edge).
//    -> outputs reach reset values immediately; after release, a new op round-trips as in test 2.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared core definitions used by the multiplier writeback path.
// Provides the scoreboard tag width and the buffered multiplier result record.
package ariane_pkg;

    // Scoreboard transaction tag width.
    localparam int unsigned TRANS_ID_BITS = 3;

    // One buffered multiplier result as it travels to writeback.
    typedef struct packed {
        logic [63:0]              result;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } mult_wb_t;

endpackage : ariane_pkg

// File: rtl/mult_wb_buffer_checker.sv
// Simulation-time protocol checks for the multiplier writeback buffer.
// Watches for overflow, a missing multiplier result, and head instability
// while writeback is stalling.
module mult_wb_buffer_checker
    import ariane_pkg::*;
(
    input logic                     clk_i,
    input logic                     rst_ni,
    input logic                     flush_i,
    input logic                     push_i,
    input logic                     pop_i,
    input logic                     full_i,
    input logic                     inflight_i,
    input logic                     mult_valid_i,
    input logic                     wb_valid_i,
    input logic                     wb_ready_i,
    input logic [63:0]              wb_result_i,
    input logic [TRANS_ID_BITS-1:0] wb_trans_id_i
);

    logic                     hold_r;
    logic [63:0]              hold_result_r;
    logic [TRANS_ID_BITS-1:0] hold_trans_id_r;

    // Check each cycle and remember whether the head was stalled, to verify it stays put.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_r          <= 1'b0;
            hold_result_r   <= 64'h0;
            hold_trans_id_r <= {TRANS_ID_BITS{1'b0}};
        end else begin
            a_push_full: assert (!(push_i && full_i && !pop_i));
            a_result_missing: assert (!(inflight_i && !mult_valid_i));
            if (hold_r) begin
                a_head_stable: assert (wb_valid_i && (wb_result_i == hold_result_r)
                                       && (wb_trans_id_i == hold_trans_id_r));
            end
            hold_r          <= wb_valid_i & ~wb_ready_i & ~flush_i;
            hold_result_r   <= wb_result_i;
            hold_trans_id_r <= wb_trans_id_i;
        end
    end

endmodule : mult_wb_buffer_checker

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers.
// The head is read straight from storage, so data written in a cycle becomes
// visible at the head one cycle later at the earliest.
// A push while full is accepted only if a pop frees the head in the same cycle.
module wb_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         dtype = mult_wb_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  dtype                       data_i,
    input  logic                       pop_i,
    output dtype                       data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] PTR_ONE = {{(CW-1){1'b0}}, 1'b1};

    dtype          mem_r [DEPTH];
    logic [CW-1:0] wptr_r;
    logic [CW-1:0] rptr_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty_o   = (wptr_r == rptr_r);
    assign full_o    = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign count_o   = wptr_r - rptr_r;
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Pointer update: flush rewinds both pointers, otherwise advance on push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_r <= {CW{1'b0}};
            rptr_r <= {CW{1'b0}};
        end else if (flush_i) begin
            wptr_r <= {CW{1'b0}};
            rptr_r <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

    // Storage write at the write pointer; cleared on reset so the array never holds X.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s && !flush_i) begin
            mem_r[wptr_r[AW-1:0]] <= data_i;
        end
    end

    // Head read: forced to zero when empty so the outputs are clean while invalid.
    always_comb begin
        data_o = '0;
        if (empty_o) begin
            data_o = '0;
        end else begin
            data_o = mem_r[rptr_r[AW-1:0]];
        end
    end

endmodule : wb_fifo

// File: rtl/mult_wb_buffer.sv
// Receiving end of the fixed 1-cycle multiplier result interface.
// Results cannot be back-pressured, so the issue stage only gets a credit when
// the FIFO can absorb the result of the op it launches, counting the op already
// in flight and any head being popped this cycle.
module mult_wb_buffer
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic                     mult_valid_i,
    input  logic [63:0]              mult_result_i,
    input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [63:0]              wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic          inflight_r;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          wb_pop_s;
    logic          empty_s;
    logic          full_s;
    logic [CW:0]   occupancy_s;
    mult_wb_t      push_data_s;
    mult_wb_t      head_s;

    // Slots committed next cycle: buffered + in flight - leaving now.
    assign wb_pop_s    = wb_valid_o & wb_ready_i;
    assign occupancy_s = {1'b0, count_o} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, wb_pop_s};

    assign issue_ready_o = ~flush_i & (occupancy_s < DEPTH_C);
    assign issue_s       = issue_valid_i & issue_ready_o;

    // A result with no op in flight belongs to a flushed op and is dropped.
    assign push_s = mult_valid_i & inflight_r & ~flush_i;
    assign pop_s  = wb_pop_s & ~flush_i;

    assign push_data_s.result   = mult_result_i;
    assign push_data_s.trans_id = mult_trans_id_i;

    // Track the single op the 1-cycle multiplier can have in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_r <= 1'b0;
        end else if (flush_i) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .dtype (mult_wb_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push_s),
        .data_i  (push_data_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .empty_o (empty_s),
        .full_o  (full_s),
        .count_o (count_o)
    );

    assign wb_valid_o    = ~empty_s;
    assign wb_result_o   = head_s.result;
    assign wb_trans_id_o = head_s.trans_id;

    mult_wb_buffer_checker u_checker (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .push_i        (push_s),
        .pop_i         (pop_s),
        .full_i        (full_s),
        .inflight_i    (inflight_r),
        .mult_valid_i  (mult_valid_i),
        .wb_valid_i    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_result_i   (wb_result_o),
        .wb_trans_id_i (wb_trans_id_o)
    );

endmodule : mult_wb_buffer

// File: tb/tb_mult_wb_buffer.sv
// Directed self-checking bench for mult_wb_buffer (DEPTH = 4).
module tb_mult_wb_buffer;
    import ariane_pkg::*;

    logic                     clk_i;
    logic                     rst_ni;
    logic                     flush_i;
    logic                     issue_valid_i;
    logic                     issue_ready_o;
    logic                     mult_valid_i;
    logic [63:0]              mult_result_i;
    logic [TRANS_ID_BITS-1:0] mult_trans_id_i;
    logic                     wb_valid_o;
    logic                     wb_ready_i;
    logic [63:0]              wb_result_o;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    logic [2:0]               count_o;

    int n_checks;
    int n_fails;
    int accepted;
    int first_rej;
    logic       pend;
    logic       pend_n;
    logic [2:0] ptag;
    logic [2:0] ptag_n;
    logic [2:0] ntag;

    mult_wb_buffer #(.DEPTH(4)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .issue_valid_i   (issue_valid_i),
        .issue_ready_o   (issue_ready_o),
        .mult_valid_i    (mult_valid_i),
        .mult_result_i   (mult_result_i),
        .mult_trans_id_i (mult_trans_id_i),
        .wb_valid_o      (wb_valid_o),
        .wb_ready_i      (wb_ready_i),
        .wb_result_o     (wb_result_o),
        .wb_trans_id_o   (wb_trans_id_o),
        .count_o         (count_o)
    );

    // Free-running 10 ns clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [63:0] res_of(input logic [2:0] tag);
        return {56'hA5A5_0000_0000_00, 5'b00000, tag};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic iv, input logic mv, input logic [2:0] tag,
                         input logic [63:0] res, input logic wr, input logic fl);
        issue_valid_i   = iv;
        mult_valid_i    = mv;
        mult_trans_id_i = tag;
        mult_result_i   = res;
        wb_ready_i      = wr;
        flush_i         = fl;
        #1;
    endtask

    // Issue one op, return its result, then pop it.
    task automatic single_op(input logic [2:0] tag, input logic [63:0] val);
        drive(1'b1, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
        check_eq("single_issue_ready", {63'h0, issue_ready_o}, 64'd1);
        tick();
        drive(1'b0, 1'b1, tag, val, 1'b0, 1'b0);
        check_eq("single_no_bypass", {63'h0, wb_valid_o}, 64'd0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
        check_eq("single_wb_valid", {63'h0, wb_valid_o}, 64'd1);
        check_eq("single_result", wb_result_o, val);
        check_eq("single_tag", {61'h0, wb_trans_id_o}, {61'h0, tag});
        check_eq("single_count1", {61'h0, count_o}, 64'd1);
        drive(1'b0, 1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
        check_eq("single_count0", {61'h0, count_o}, 64'd0);
        check_eq("single_empty", {63'h0, wb_valid_o}, 64'd0);
    endtask

    // Back-to-back issues tagged 0..n-1; leaves tag n-1 in flight and n-1 buffered.
    task automatic chain(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, (k > 0), 3'(k - 1), res_of(3'(k - 1)), 1'b0, 1'b0);
            tick();
        end
    endtask

    // Pop n entries, expecting consecutive tags from start.
    task automatic drain(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
            check_eq("drain_valid", {63'h0, wb_valid_o}, 64'd1);
            check_eq("drain_tag", {61'h0, wb_trans_id_o}, {61'h0, 3'(start + i)});
            check_eq("drain_result", wb_result_o, res_of(3'(start + i)));
            tick();
        end
        drive(1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
        check_eq("drain_count0", {61'h0, count_o}, 64'd0);
    endtask

    // Directed test sequence.
    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_ni   = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);

        // 1: reset
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_wb_valid", {63'h0, wb_valid_o}, 64'd0);
        check_eq("rst_count", {61'h0, count_o}, 64'd0);
        check_eq("rst_issue_ready", {63'h0, issue_ready_o}, 64'd1);
        check_eq("rst_result", wb_result_o, 64'h0);
        check_eq("rst_tag", {61'h0, wb_trans_id_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // 2: single op
        single_op(3'd5, 64'h0000_0000_DEAD_BEEF);

        // 3: fill under backpressure
        accepted  = 0;
        first_rej = -1;
        pend      = 1'b0;
        ptag      = 3'd0;
        ntag      = 3'd0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, pend, ptag, res_of(ptag), 1'b0, 1'b0);
            if (issue_ready_o) begin
                accepted++;
                pend_n = 1'b1;
                ptag_n = ntag;
                ntag   = ntag + 3'd1;
            end else begin
                pend_n = 1'b0;
                ptag_n = 3'd0;
                if (first_rej < 0) first_rej = c;
            end
            tick();
            pend = pend_n;
            ptag = ptag_n;
        end
        drive(1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
        check_eq("fill_accepted", 64'(accepted), 64'd4);
        check_eq("fill_first_reject", 64'(first_rej), 64'd4);
        check_eq("fill_count", {61'h0, count_o}, 64'd4);
        check_eq("fill_ready_low", {63'h0, issue_ready_o}, 64'd0);
        drain(0, 4);

        // 4: count 3 + 1 in flight, pop frees a slot for a new issue
        chain(4);
        drive(1'b1, 1'b1, 3'd3, res_of(3'd3), 1'b1, 1'b0);
        check_eq("cpop_count3", {61'h0, count_o}, 64'd3);
        check_eq("cpop_issue_ready", {63'h0, issue_ready_o}, 64'd1);
        tick();
        drive(1'b0, 1'b1, 3'd4, res_of(3'd4), 1'b0, 1'b0);
        check_eq("cpop_count_after", {61'h0, count_o}, 64'd3);
        check_eq("cpop_head", {61'h0, wb_trans_id_o}, 64'd1);
        tick();
        drive(1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
        check_eq("cpop_count_full", {61'h0, count_o}, 64'd4);
        check_eq("cpop_ready_full", {63'h0, issue_ready_o}, 64'd0);
        drain(1, 4);

        // 5: flush with 2 buffered and 1 in flight
        chain(3);
        drive(1'b1, 1'b1, 3'd7, res_of(3'd7), 1'b0, 1'b1);
        check_eq("flush_count_before", {61'h0, count_o}, 64'd2);
        check_eq("flush_ready_during", {63'h0, issue_ready_o}, 64'd0);
        tick();
        drive(1'b0, 1'b1, 3'd6, res_of(3'd6), 1'b0, 1'b0);
        check_eq("flush_count_after", {61'h0, count_o}, 64'd0);
        check_eq("flush_valid_after", {63'h0, wb_valid_o}, 64'd0);
        check_eq("flush_ready_after", {63'h0, issue_ready_o}, 64'd1);
        tick();
        drive(1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
        check_eq("flush_dropped_count", {61'h0, count_o}, 64'd0);
        check_eq("flush_dropped_valid", {63'h0, wb_valid_o}, 64'd0);

        // 6: asynchronous reset mid-operation
        chain(4);
        drive(1'b0, 1'b1, 3'd3, res_of(3'd3), 1'b0, 1'b0);
        check_eq("mid_count_before", {61'h0, count_o}, 64'd3);
        #1;
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
        check_eq("mid_rst_valid", {63'h0, wb_valid_o}, 64'd0);
        check_eq("mid_rst_count", {61'h0, count_o}, 64'd0);
        check_eq("mid_rst_result", wb_result_o, 64'h0);
        check_eq("mid_rst_tag", {61'h0, wb_trans_id_o}, 64'd0);
        check_eq("mid_rst_ready", {63'h0, issue_ready_o}, 64'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        single_op(3'd2, 64'h0123_4567_89AB_CDEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule : tb_mult_wb_buffer
